// File: rtl/uart_axi_tx_sequencer.sv
// Single-beat AXI4 master that polls the UART STATUS register until TX is not full, then writes one byte to TXDATA.
// Optional poll timeout is compiled in with `define POLL_TIMEOUT_EN.
module uart_axi_tx_sequencer #(
  parameter logic [31:0] STATUS_ADDR = 32'h0000_0004,
  parameter logic [31:0] TXDATA_ADDR = 32'h0000_0000,
  parameter int          TXFULL_BIT  = 0
`ifdef POLL_TIMEOUT_EN
  , parameter int        TIMEOUT_CYC = 1024
`endif
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [7:0]  In_data,
  input  logic        In_valid,
  output logic        In_ready,
  output logic        Err,
  output logic [31:0] AW_add,
  output logic        AW_valid,
  input  logic        AW_ready,
  output logic [31:0] W_data,
  output logic [3:0]  W_strb,
  output logic        W_valid,
  output logic        W_last,
  input  logic        W_ready,
  input  logic        B_valid,
  input  logic [1:0]  B_response,
  output logic        B_ready,
  output logic [31:0] AR_add,
  output logic        AR_valid,
  input  logic        AR_ready,
  input  logic [31:0] R_data,
  input  logic        R_valid,
  input  logic [1:0]  R_resp,
  output logic        R_ready,
  output logic [2:0]  dbg_state
);

  // Handshake rule on every channel: a transfer happens on the rising edge where
  // valid && ready; a raised valid (and its payload) holds until that edge.
  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B} state_t;

  state_t     state_q, state_n;
  logic [7:0] byte_q, byte_n;
  logic       in_ready_n, err_n;
  logic       ar_valid_n, r_ready_n, aw_valid_n, w_valid_n, b_ready_n;
  logic       poll_expired;
  logic       unused_rdata;

  assign dbg_state    = state_q;
  assign unused_rdata = ^R_data;

`ifdef POLL_TIMEOUT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if ((state_q == RD_A || state_q == RD_D) && cnt_q != '1) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign poll_expired = (cnt_q >= 32'(TIMEOUT_CYC - 1));
`else
  assign poll_expired = 1'b0;
`endif

  always_comb begin
    state_n    = state_q;
    byte_n     = byte_q;
    in_ready_n = 1'b0;
    err_n      = 1'b0;
    ar_valid_n = AR_valid;
    r_ready_n  = R_ready;
    aw_valid_n = AW_valid;
    w_valid_n  = W_valid;
    b_ready_n  = B_ready;
    case (state_q)
      IDLE: begin
        if (In_valid) begin
          byte_n     = In_data;
          in_ready_n = 1'b1;
          ar_valid_n = 1'b1;
          state_n    = RD_A;
        end
      end
      RD_A: begin
        if (AR_valid && AR_ready) begin
          ar_valid_n = 1'b0;
          r_ready_n  = 1'b1;
          state_n    = RD_D;
        end
      end
      RD_D: begin
        if (R_valid && R_ready) begin
          r_ready_n = 1'b0;
          if (R_resp != 2'b00) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else if (R_data[TXFULL_BIT]) begin
            if (poll_expired) begin
              err_n   = 1'b1;
              state_n = IDLE;
            end else begin
              ar_valid_n = 1'b1;
              state_n    = RD_A;
            end
          end else begin
            aw_valid_n = 1'b1;
            w_valid_n  = 1'b1;
            state_n    = WR;
          end
        end
      end
      WR: begin
        // AW and W complete independently, in either order.
        if (AW_valid && AW_ready) aw_valid_n = 1'b0;
        if (W_valid && W_ready)   w_valid_n  = 1'b0;
        if (!aw_valid_n && !w_valid_n) begin
          b_ready_n = 1'b1;
          state_n   = WR_B;
        end
      end
      WR_B: begin
        if (B_valid && B_ready) begin
          b_ready_n = 1'b0;
          err_n     = (B_response != 2'b00);
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      byte_q   <= '0;
      In_ready <= 1'b0;
      Err      <= 1'b0;
      AR_valid <= 1'b0;
      AR_add   <= '0;
      R_ready  <= 1'b0;
      AW_valid <= 1'b0;
      AW_add   <= '0;
      W_valid  <= 1'b0;
      W_data   <= '0;
      W_strb   <= '0;
      W_last   <= 1'b0;
      B_ready  <= 1'b0;
    end else begin
      state_q  <= state_n;
      byte_q   <= byte_n;
      In_ready <= in_ready_n;
      Err      <= err_n;
      AR_valid <= ar_valid_n;
      AR_add   <= ar_valid_n ? STATUS_ADDR : 32'd0;
      R_ready  <= r_ready_n;
      AW_valid <= aw_valid_n;
      AW_add   <= aw_valid_n ? TXDATA_ADDR : 32'd0;
      W_valid  <= w_valid_n;
      W_data   <= w_valid_n ? {24'd0, byte_q} : 32'd0;
      W_strb   <= w_valid_n ? 4'b0001 : 4'b0000;
      W_last   <= w_valid_n;
      B_ready  <= b_ready_n;
    end
  end

endmodule

// File: tb/tb_uart_axi_tx_sequencer.sv
// Bench for uart_axi_tx_sequencer: a responsive AXI slave model plus per-byte expectations
// derived from the poll/write rules (poll count, written word, error pulse, timing).
module tb_uart_axi_tx_sequencer;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [7:0]  In_data = '0;
  logic        In_valid = 1'b0;
  logic        In_ready, Err;
  logic [31:0] AW_add, W_data, AR_add;
  logic        AW_valid, W_valid, W_last, B_ready, AR_valid, R_ready;
  logic [3:0]  W_strb;
  logic [2:0]  dbg_state;
  logic        AW_ready = 1'b0, W_ready = 1'b0, B_valid = 1'b0, AR_ready = 1'b0, R_valid = 1'b0;
  logic [1:0]  B_response = '0, R_resp = '0;
  logic [31:0] R_data = '0;

  uart_axi_tx_sequencer dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_data(In_data), .In_valid(In_valid), .In_ready(In_ready),
    .Err(Err), .AW_add(AW_add), .AW_valid(AW_valid), .AW_ready(AW_ready), .W_data(W_data),
    .W_strb(W_strb), .W_valid(W_valid), .W_last(W_last), .W_ready(W_ready), .B_valid(B_valid),
    .B_response(B_response), .B_ready(B_ready), .AR_add(AR_add), .AR_valid(AR_valid),
    .AR_ready(AR_ready), .R_data(R_data), .R_valid(R_valid), .R_resp(R_resp), .R_ready(R_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;
  int cyc = 0;
  always @(posedge Clk) cyc++;

  int vec = 0, miss = 0;
  logic [31:0] exp_q[$];

  // ---------------- slave model and monitor ----------------
  int cfg_full_polls = 0, cfg_rerr_poll = -1, cfg_aw_delay = 0, cfg_w_delay = 0, cfg_ar_base = 0;
  logic [1:0] cfg_bresp = 2'b00;
  int n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, n_err = 0, n_inr = 0, n_viol = 0;
  logic [31:0] ar_addr_q[$], aw_addr_q[$], w_data_q[$];
  logic [3:0]  w_strb_q[$];
  logic        w_last_q[$];
  int aw_hold_q[$], w_hold_q[$], inr_cyc_q[$], ar_rise_q[$], aw_rise_q[$];
  bit r_pend, aw_done, w_done, b_pend;
  int aw_cnt, w_cnt, aw_hold, w_hold, poll_idx;
  bit prev_ar_v, prev_ar_hs, prev_aw_v, prev_aw_hs, prev_w_v, prev_w_hs;
  logic [31:0] prev_ar_add, prev_aw_add, prev_w_data, rd_word;

  always @(negedge Clk) begin
    if (!Rst_n) begin
      AR_ready = 0; R_valid = 0; R_data = 0; R_resp = 0; AW_ready = 0; W_ready = 0;
      B_valid = 0; B_response = 0;
      r_pend = 0; aw_done = 0; w_done = 0; b_pend = 0; aw_cnt = 0; w_cnt = 0;
      aw_hold = 0; w_hold = 0;
      prev_ar_v = 0; prev_ar_hs = 0; prev_aw_v = 0; prev_aw_hs = 0; prev_w_v = 0; prev_w_hs = 0;
    end else begin
      if (prev_ar_v && !prev_ar_hs && (!AR_valid || AR_add != prev_ar_add)) n_viol++;
      if (prev_aw_v && !prev_aw_hs && (!AW_valid || AW_add != prev_aw_add)) n_viol++;
      if (prev_w_v && !prev_w_hs && (!W_valid || W_data != prev_w_data)) n_viol++;
      if (W_last !== W_valid) n_viol++;
      if (AR_valid && !prev_ar_v) ar_rise_q.push_back(cyc);
      if (AW_valid && !prev_aw_v) aw_rise_q.push_back(cyc);
      if (In_ready) begin n_inr++; inr_cyc_q.push_back(cyc); end
      if (Err) n_err++;
      // read data answers the previous address handshake
      R_valid = 0; R_data = 0; R_resp = 0;
      if (r_pend && R_ready) begin
        poll_idx = n_ar - 1 - cfg_ar_base;
        rd_word = $urandom;
        rd_word[0] = (poll_idx < cfg_full_polls);
        R_valid = 1; R_data = rd_word;
        R_resp = (poll_idx == cfg_rerr_poll) ? 2'b10 : 2'b00;
        r_pend = 0;
      end
      AR_ready = AR_valid;
      if (AR_valid) begin n_ar++; ar_addr_q.push_back(AR_add); r_pend = 1; end
      AW_ready = 0;
      if (AW_valid && !aw_done) begin
        aw_hold++;
        if (aw_cnt >= cfg_aw_delay) begin
          AW_ready = 1; n_aw++; aw_addr_q.push_back(AW_add); aw_hold_q.push_back(aw_hold);
          aw_hold = 0; aw_cnt = 0; aw_done = 1;
        end else aw_cnt++;
      end
      W_ready = 0;
      if (W_valid && !w_done) begin
        w_hold++;
        if (w_cnt >= cfg_w_delay) begin
          W_ready = 1; n_w++; w_data_q.push_back(W_data); w_strb_q.push_back(W_strb);
          w_last_q.push_back(W_last); w_hold_q.push_back(w_hold);
          w_hold = 0; w_cnt = 0; w_done = 1;
        end else w_cnt++;
      end
      B_valid = 0; B_response = 0;
      if (b_pend && B_ready) begin B_valid = 1; B_response = cfg_bresp; b_pend = 0; n_b++; end
      if (aw_done && w_done) begin b_pend = 1; aw_done = 0; w_done = 0; end
      prev_ar_v = AR_valid; prev_ar_hs = AR_valid && AR_ready; prev_ar_add = AR_add;
      prev_aw_v = AW_valid; prev_aw_hs = AW_valid && AW_ready; prev_aw_add = AW_add;
      prev_w_v = W_valid; prev_w_hs = W_valid && W_ready; prev_w_data = W_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_byte(input logic [7:0] b, output bit got);
    @(negedge Clk); #1;
    In_data = b; In_valid = 1'b1; got = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk); #1;
      if (In_ready) begin got = 1; break; end
    end
    In_valid = 1'b0;
  endtask

  task automatic run_byte(input logic [7:0] b, input int full_polls, input int rerr_poll,
                          input logic [1:0] bresp, input int awd, input int wd);
    int ar0, aw0, w0, b0, e0, i0, v0, exp_ar, exp_wr, exp_err;
    bit got;
    cfg_full_polls = full_polls; cfg_rerr_poll = rerr_poll; cfg_bresp = bresp;
    cfg_aw_delay = awd; cfg_w_delay = wd; cfg_ar_base = n_ar;
    ar0 = n_ar; aw0 = n_aw; w0 = n_w; b0 = n_b; e0 = n_err; i0 = n_inr; v0 = n_viol;
    // reference: polls run until the first non-full or error response
    exp_ar  = (rerr_poll >= 0) ? rerr_poll + 1 : full_polls + 1;
    exp_wr  = (rerr_poll >= 0) ? 0 : 1;
    exp_err = (rerr_poll >= 0 || bresp != 2'b00) ? 1 : 0;
    if (exp_wr == 1) exp_q.push_back({24'd0, b});
    start_byte(b, got);
    vec++;
    if (!got) begin miss++; $display("FAIL accept byte=%h: In_ready never seen, want 1", b); end
    for (int k = 0; k < 400; k++) begin
      @(negedge Clk); #1;
      if (n_b > b0 || n_err > e0) break;
    end
    repeat (3) @(negedge Clk);
    #1;
    vec++;
    if (n_ar - ar0 !== exp_ar) begin miss++; $display("FAIL ar_count byte=%h: got %0d want %0d", b, n_ar - ar0, exp_ar); end
    vec++;
    if (n_inr - i0 !== 1) begin miss++; $display("FAIL in_ready_pulses byte=%h: got %0d want 1", b, n_inr - i0); end
    vec++;
    if (n_err - e0 !== exp_err) begin miss++; $display("FAIL err_pulses byte=%h: got %0d want %0d", b, n_err - e0, exp_err); end
    vec++;
    if (n_aw - aw0 !== exp_wr || n_w - w0 !== exp_wr || n_b - b0 !== exp_wr) begin
      miss++; $display("FAIL write_count byte=%h: aw %0d w %0d b %0d want %0d", b, n_aw - aw0, n_w - w0, n_b - b0, exp_wr);
    end
    vec++;
    if (n_viol !== v0) begin miss++; $display("FAIL protocol byte=%h: violations %0d want 0", b, n_viol - v0); end
    for (int k = ar0; k < n_ar; k++) begin
      vec++;
      if (ar_addr_q[k] !== 32'h4) begin miss++; $display("FAIL ar_addr: got %h want 00000004", ar_addr_q[k]); end
    end
    if (exp_wr == 1 && n_w > w0 && n_aw > aw0) begin
      logic [31:0] want;
      want = exp_q.pop_front();
      vec++;
      if (w_data_q[n_w-1] !== want || w_strb_q[n_w-1] !== 4'b0001 || w_last_q[n_w-1] !== 1'b1 || aw_addr_q[n_aw-1] !== 32'h0) begin
        miss++; $display("FAIL write_beat: data %h strb %b last %b addr %h want %h 0001 1 00000000",
                         w_data_q[n_w-1], w_strb_q[n_w-1], w_last_q[n_w-1], aw_addr_q[n_aw-1], want);
      end
    end else if (exp_wr == 1) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic check_all_zero(input string name);
    vec++;
    if ({In_ready, Err, AW_valid, W_valid, W_last, B_ready, AR_valid, R_ready, AW_add, AR_add, W_data, W_strb} !== '0) begin
      miss++; $display("FAIL %s: outputs not all zero (aw_v %b w_v %b ar_v %b aw_add %h w_data %h)", name, AW_valid, W_valid, AR_valid, AW_add, W_data);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    check_all_zero("reset_state");
    Rst_n = 1'b1;
    @(negedge Clk); #1;
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_basic();
    run_byte(8'h41, 0, -1, 2'b00, 0, 0);
    vec++;
    if (aw_rise_q[$] - ar_rise_q[$] !== 2) begin
      miss++; $display("FAIL ar_to_aw_latency: got %0d want 2", aw_rise_q[$] - ar_rise_q[$]);
    end
  endtask

  task automatic test_full_polls();
    run_byte(8'(($urandom)), 3, -1, 2'b00, 0, 0);
  endtask

  task automatic test_aw_delay();
    run_byte(8'h5a, 0, -1, 2'b00, 2, 0);
    vec++;
    if (aw_hold_q[$] !== 3 || w_hold_q[$] !== 1) begin
      miss++; $display("FAIL valid_hold: aw %0d w %0d want aw 3 w 1", aw_hold_q[$], w_hold_q[$]);
    end
    run_byte(8'ha5, 0, -1, 2'b00, 0, 3);
  endtask

  task automatic test_resp_errors();
    run_byte(8'h13, 0, 0, 2'b00, 0, 0);
    run_byte(8'h42, 0, -1, 2'b00, 0, 0);
    run_byte(8'h77, 2, 1, 2'b00, 0, 0);
    run_byte(8'h88, 0, -1, 2'b10, 1, 1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    int i0, w0, k;
    bit ok;
    cfg_full_polls = 0; cfg_rerr_poll = -1; cfg_bresp = 2'b00; cfg_aw_delay = 0; cfg_w_delay = 0;
    i0 = inr_cyc_q.size(); w0 = n_w;
    foreach (bytes[j]) begin bytes[j] = 8'($urandom); exp_q.push_back({24'd0, bytes[j]}); end
    @(negedge Clk); #1;
    In_valid = 1'b1; In_data = bytes[0];
    for (int j = 0; j < 4; j++) begin
      ok = 0;
      for (k = 0; k < 20; k++) begin
        @(negedge Clk); #1;
        if (In_ready) begin ok = 1; break; end
      end
      vec++;
      if (!ok) begin miss++; $display("FAIL b2b_accept %0d: In_ready never seen, want 1", j); end
      if (j < 3) In_data = bytes[j+1];
      else In_valid = 1'b0;
    end
    repeat (8) @(negedge Clk);
    #1;
    for (int j = 1; j < 4; j++) begin
      vec++;
      if (inr_cyc_q.size() < i0 + 4) begin
        miss++; $display("FAIL b2b_pulses: got %0d want 4", inr_cyc_q.size() - i0); break;
      end
      if (inr_cyc_q[i0+j] - inr_cyc_q[i0+j-1] !== 5) begin
        miss++; $display("FAIL b2b_interval %0d: got %0d want 5", j, inr_cyc_q[i0+j] - inr_cyc_q[i0+j-1]);
      end
    end
    for (int j = 0; j < 4; j++) begin
      logic [31:0] want;
      want = exp_q.pop_front();
      vec++;
      if (w0 + j >= n_w) begin miss++; $display("FAIL b2b_data %0d: missing write, want %h", j, want); end
      else if (w_data_q[w0+j] !== want) begin miss++; $display("FAIL b2b_data %0d: got %h want %h", j, w_data_q[w0+j], want); end
    end
  endtask

  task automatic test_reset_mid();
    bit got, seen;
    int aw0;
    cfg_full_polls = 0; cfg_rerr_poll = -1; cfg_bresp = 2'b00; cfg_aw_delay = 20; cfg_w_delay = 20;
    cfg_ar_base = n_ar; aw0 = n_aw;
    start_byte(8'h99, got);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (AW_valid) begin seen = 1; break; end
      @(negedge Clk); #1;
    end
    vec++;
    if (!seen) begin miss++; $display("FAIL mid_reset_setup: AW_valid never seen, want 1"); end
    Rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset_async");
    repeat (2) @(negedge Clk);
    #1;
    Rst_n = 1'b1;
    vec++;
    if (n_aw !== aw0) begin miss++; $display("FAIL mid_reset_abandon: aw handshakes %0d want 0", n_aw - aw0); end
    run_byte(8'h42, 0, -1, 2'b00, 0, 0);
  endtask

  task automatic test_no_timeout();
    bit got;
    int e0, w0, exp_err, budget;
`ifdef POLL_TIMEOUT_EN
    exp_err = 1; budget = 1100;
`else
    exp_err = 0; budget = 1000;
`endif
    cfg_full_polls = 1000000; cfg_rerr_poll = -1; cfg_bresp = 2'b00; cfg_aw_delay = 0; cfg_w_delay = 0;
    cfg_ar_base = n_ar; e0 = n_err; w0 = n_w;
    start_byte(8'h3c, got);
    repeat (budget) @(negedge Clk);
    #1;
    vec++;
    if (n_err - e0 !== exp_err) begin miss++; $display("FAIL poll_forever_err: got %0d want %0d", n_err - e0, exp_err); end
    vec++;
    if (n_w !== w0 || n_ar - cfg_ar_base < 100) begin
      miss++; $display("FAIL poll_forever_activity: writes %0d polls %0d want 0 writes, >=100 polls", n_w - w0, n_ar - cfg_ar_base);
    end
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      int fp, re;
      logic [1:0] br;
      fp = $urandom_range(0, 3);
      re = ($urandom_range(0, 3) == 0) ? $urandom_range(0, fp) : -1;
      br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_byte(8'($urandom), fp, re, br, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_polls();
    test_aw_delay();
    test_resp_errors();
    test_back_to_back();
    test_reset_mid();
    test_no_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
